// File: rtl/composite_timing_gen.sv
// Composite video timing generator: a phase accumulator paces a raster of
// hcount/vcount positions that produces composite sync, video level and active flags.
module composite_timing_gen #(
    parameter int ACC_W        = 16,
    parameter int H_TOTAL      = 504,
    parameter int H_SYNC       = 37,
    parameter int H_ACT_START  = 96,
    parameter int H_ACT_END    = 480,
    parameter int V_TOTAL      = 262,
    parameter int V_SYNC_LINES = 3,
    parameter int V_ACT_START  = 20,
    parameter int V_ACT_END    = 260,
    localparam int HW          = $clog2(H_TOTAL),
    localparam int VW          = $clog2(V_TOTAL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    input  logic             interlace,
    input  logic [1:0]       pixel_in,
    output logic             tick,
    output logic [HW-1:0]    hcount,
    output logic [VW-1:0]    vcount,
    output logic             field,
    output logic             sync_n,
    output logic [1:0]       level,
    output logic             active,
    output logic             frame_start
);

    if (!(H_SYNC < H_ACT_START && H_ACT_START < H_ACT_END && H_ACT_END <= H_TOTAL &&
          V_SYNC_LINES <= V_ACT_START && V_ACT_START < V_ACT_END && V_ACT_END <= V_TOTAL &&
          H_TOTAL - H_SYNC > H_SYNC)) begin : g_bad_params
        $error("composite_timing_gen: inconsistent timing parameters");
    end

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             en;
    logic             mode;

    logic          h_wrap, v_wrap;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt, v_last;
    logic          field_nxt, mode_nxt, sync_nxt, act_nxt;
    logic [1:0]    lvl_nxt;

    assign sum = {1'b0, acc} + {1'b0, inc};
    assign en  = sum[ACC_W];

    // Next raster position and the outputs that belong to it, all committed on en.
    always_comb begin
        h_wrap    = (hcount == HW'(H_TOTAL - 1));
        h_nxt     = h_wrap ? '0 : hcount + HW'(1);
        // The odd field of an interlaced frame carries one extra line.
        v_last    = (field && mode) ? VW'(V_TOTAL) : VW'(V_TOTAL - 1);
        v_wrap    = h_wrap && (vcount == v_last);
        v_nxt     = vcount;
        if (h_wrap) v_nxt = v_wrap ? '0 : vcount + VW'(1);
        mode_nxt  = v_wrap ? interlace : mode;
        field_nxt = field;
        if (v_wrap) field_nxt = interlace ? ~field : 1'b0;
        if (int'(v_nxt) < V_SYNC_LINES) sync_nxt = !(int'(h_nxt) < H_TOTAL - H_SYNC);
        else                            sync_nxt = !(int'(h_nxt) < H_SYNC);
        act_nxt   = (int'(h_nxt) >= H_ACT_START) && (int'(h_nxt) < H_ACT_END) &&
                    (int'(v_nxt) >= V_ACT_START) && (int'(v_nxt) < V_ACT_END);
        lvl_nxt   = 2'b01;
        if (!sync_nxt)                        lvl_nxt = 2'b00;
        else if (act_nxt && pixel_in != 2'b00) lvl_nxt = pixel_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            hcount      <= HW'(H_TOTAL - 1);
            vcount      <= VW'(V_TOTAL - 1);
            field       <= 1'b1;
            mode        <= 1'b0;
            tick        <= 1'b0;
            sync_n      <= 1'b1;
            level       <= 2'b01;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            acc         <= sum[ACC_W-1:0];
            tick        <= en;
            frame_start <= en && v_wrap;
            if (en) begin
                hcount <= h_nxt;
                vcount <= v_nxt;
                field  <= field_nxt;
                mode   <= mode_nxt;
                sync_n <= sync_nxt;
                level  <= lvl_nxt;
                active <= act_nxt;
            end
        end
    end

endmodule

// File: doc/composite_timing_gen.md
COMPOSITE_TIMING_GEN -- requirements
Module: composite_timing_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 16, phase-accumulator width.
REQ-002 SHALL have parameters H_TOTAL 504, H_SYNC 37, H_ACT_START 96, H_ACT_END 480: ticks per line and horizontal boundaries.
REQ-003 SHALL have parameters V_TOTAL 262, V_SYNC_LINES 3, V_ACT_START 20, V_ACT_END 260: lines per field and vertical boundaries.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk and rst, with rst sampled only on posedge clk.
REQ-005 SHALL have the following ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inc  in  ACC_W  phase increment, sampled every clk
- interlace  in  1  mode request, sampled only at frame wrap
- pixel_in  in  2  picture level for the current position
- tick  out  1  one-clk pulse per timing step
- hcount  out  clog2(H_TOTAL)  horizontal position
- vcount  out  clog2(V_TOTAL+1)  line within field
- field  out  1  field index
- sync_n  out  1  composite sync, low = sync
- level  out  2  video level: 00 sync, 01 black, 10/11 picture
- active  out  1  inside active picture
- frame_start  out  1  one-clk pulse at position (0,0)

Function
REQ-006 SHALL add inc to the ACC_W-bit accumulator each clk; the internal enable is the carry out of that add; tick SHALL be registered, high the clk after a carry.
REQ-007 With inc=0, SHALL never tick; all other outputs hold.
REQ-008 With inc=2^(ACC_W-1), SHALL tick every second clk.
REQ-009 On each enable, hcount SHALL advance by 1 and wrap from H_TOTAL-1 to 0.
REQ-010 On each hcount wrap, vcount SHALL advance by 1; it wraps to 0 after the last line of the field.
REQ-011 The last line SHALL be V_TOTAL-1 when field=0 or the latched mode is 0, and V_TOTAL when field=1 with the latched mode 1.
REQ-012 At each vcount wrap, SHALL latch interlace; field toggles if the newly latched mode is 1, else becomes 0; frame_start pulses when (0,0) is entered.
REQ-013 Normal line: sync_n low iff hcount < H_SYNC.
REQ-014 Lines vcount < V_SYNC_LINES: sync_n low iff hcount < H_TOTAL-H_SYNC (broad pulses).
REQ-015 active SHALL be high iff H_ACT_START <= hcount < H_ACT_END and V_ACT_START <= vcount < V_ACT_END.
REQ-016 level SHALL be 00 when sync_n is low; pixel_in when active (00 coerced to 01); 01 otherwise.
REQ-017 hcount, vcount, field, sync_n, level, active and frame_start SHALL all be registered, update in the same clk (the clk after an enable) and be mutually consistent.
REQ-018 pixel_in SHALL be sampled on the enable clk.
REQ-019 A change on inc SHALL take effect on the next accumulator add, with no output glitch.
REQ-020 Elaboration SHALL fail unless H_SYNC < H_ACT_START < H_ACT_END <= H_TOTAL, V_SYNC_LINES <= V_ACT_START < V_ACT_END <= V_TOTAL and H_TOTAL-H_SYNC > H_SYNC.

Reset
REQ-021 On rst: accumulator=0; hcount=H_TOTAL-1, vcount=V_TOTAL-1; field=1; latched mode=0.
REQ-022 On rst: tick=0, sync_n=1, level=01, active=0, frame_start=0.
REQ-023 The first enable after rst SHALL land on (0,0), field=0, and pulse frame_start.
REQ-024 rst mid-line or mid-field SHALL take priority over an enable in the same clk.

Verification
Bench parameters: H_TOTAL=16, H_SYNC=2, H_ACT 4..14, V_TOTAL=8, V_SYNC_LINES=1, V_ACT 2..7, ACC_W=4.
REQ-025 SHALL cover: inc=8 after rst -> tick every 2nd clk; frame_start 2 clk after rst release; next frame_start 256 clk later.
REQ-026 SHALL cover: inc=0 for 50 clk mid-line -> no tick; all outputs frozen.
REQ-027 SHALL cover: line 0 -> sync_n low for hcount 0..13; line 1 -> low for 0..1; level=00 exactly where sync_n=0.
REQ-028 SHALL cover: pixel_in=00 at (5,3) -> level=01, active=1; pixel_in=11 at (14,3) -> level=01, active=0.
REQ-029 SHALL cover: interlace=1 set mid-field -> no effect until wrap; then field alternates 0/1 with 8/9 lines; clear -> next field=0, 8 lines.
REQ-030 SHALL cover: rst asserted at (9,5) in the same clk as an enable -> REQ-021/022 values next clk, no frame_start.
